// File: rtl/traffic_phase_controller.sv
// Two-road intersection light sequencer. Turns the divider's 1 Hz square wave
// into one-clock second ticks and steps a six-phase cycle timed in those ticks.
module traffic_phase_controller #(
  parameter int MAIN_GREEN_S = 10,
  parameter int SIDE_GREEN_S = 6,
  parameter int YELLOW_S     = 3,
  parameter int ALLRED_S     = 1,
  parameter int TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               controller_reset,
  input  logic               Hz1_enable,
  input  logic               side_sensor,
  output logic [2:0]         main_lights,
  output logic [2:0]         side_lights,
  output logic [2:0]         phase,
  output logic               sec_tick,
  output logic [TIMER_W-1:0] time_left
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] MAIN_GREEN_D = TIMER_W'(MAIN_GREEN_S);
  localparam logic [TIMER_W-1:0] SIDE_GREEN_D = TIMER_W'(SIDE_GREEN_S);
  localparam logic [TIMER_W-1:0] YELLOW_D     = TIMER_W'(YELLOW_S);
  localparam logic [TIMER_W-1:0] ALLRED_D     = TIMER_W'(ALLRED_S);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  state_t               state_q, state_d;
  state_t               next_phase;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   next_dur;
  logic                 hz_prev_q;
  logic                 sec_tick_q;

  // hz_prev resets high so a reference already high at release is not a rising edge.
  always_ff @(posedge clk) begin
    if (controller_reset) begin
      hz_prev_q  <= 1'b1;
      sec_tick_q <= 1'b0;
      state_q    <= ALLRED_B;
      timer_q    <= ALLRED_D;
    end else begin
      hz_prev_q  <= Hz1_enable;
      sec_tick_q <= Hz1_enable & ~hz_prev_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    next_phase = ALLRED_B;
    next_dur   = ALLRED_D;
    case (state_q)
      MAIN_GREEN: begin
        next_phase = MAIN_YELLOW;
        next_dur   = YELLOW_D;
      end
      MAIN_YELLOW: begin
        next_phase = ALLRED_A;
        next_dur   = ALLRED_D;
      end
      ALLRED_A: begin
        next_phase = SIDE_GREEN;
        next_dur   = SIDE_GREEN_D;
      end
      SIDE_GREEN: begin
        next_phase = SIDE_YELLOW;
        next_dur   = YELLOW_D;
      end
      SIDE_YELLOW: begin
        next_phase = ALLRED_B;
        next_dur   = ALLRED_D;
      end
      ALLRED_B: begin
        next_phase = MAIN_GREEN;
        next_dur   = MAIN_GREEN_D;
      end
      default: begin
        next_phase = ALLRED_B;
        next_dur   = ALLRED_D;
      end
    endcase
  end

  // Timer counts down to 1 and the phase ends on the tick seen at 1; main green
  // parks at 1 until a tick arrives with a side vehicle waiting.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q > ALLRED_B) begin
      state_d = ALLRED_B;
      timer_d = ALLRED_D;
    end else if (sec_tick_q) begin
      if (timer_q > TIMER_ONE) begin
        timer_d = timer_q - TIMER_ONE;
      end else if ((state_q == MAIN_GREEN) && !side_sensor) begin
        timer_d = TIMER_ONE;
      end else begin
        state_d = next_phase;
        timer_d = next_dur;
      end
    end
  end

  always_comb begin
    main_lights = 3'b100;
    side_lights = 3'b100;
    case (state_q)
      MAIN_GREEN:  main_lights = 3'b001;
      MAIN_YELLOW: main_lights = 3'b010;
      SIDE_GREEN:  side_lights = 3'b001;
      SIDE_YELLOW: side_lights = 3'b010;
      default: begin
        main_lights = 3'b100;
        side_lights = 3'b100;
      end
    endcase
  end

  assign phase     = state_q;
  assign sec_tick  = sec_tick_q;
  assign time_left = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomised and directed bench for traffic_phase_controller, checked each clock
// against a phase/elapsed-seconds model of the light cycle.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       controller_reset = 1'b1;
  logic       Hz1_enable = 1'b1;
  logic       side_sensor = 1'b1;
  logic [2:0] main_lights, side_lights, phase;
  logic       sec_tick;
  logic [7:0] time_left;

  traffic_phase_controller #(
    .MAIN_GREEN_S(4), .SIDE_GREEN_S(3), .YELLOW_S(2), .ALLRED_S(1), .TIMER_W(8)
  ) dut (
    .clk(clk), .controller_reset(controller_reset), .Hz1_enable(Hz1_enable),
    .side_sensor(side_sensor), .main_lights(main_lights), .side_lights(side_lights),
    .phase(phase), .sec_tick(sec_tick), .time_left(time_left)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int ticks   = 0;
  int hc      = 0;

  // Model: current phase index and whole seconds already spent in it.
  int   m_phase   = 5;
  int   m_elapsed = 0;
  logic m_prev    = 1'b1;
  logic m_tick    = 1'b0;

  function automatic int dur(input int p);
    case (p)
      0: return 4;
      1: return 2;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] main_exp(input int p);
    return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] side_exp(input int p);
    return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic h, input logic s);
    logic tick_now;
    if (r) begin
      m_prev = 1'b1; m_tick = 1'b0; m_phase = 5; m_elapsed = 0;
    end else begin
      tick_now = m_tick;
      m_tick   = h & ~m_prev;
      m_prev   = h;
      if (tick_now) begin
        m_elapsed++;
        if (m_elapsed >= dur(m_phase)) begin
          if (m_phase == 0 && !s) m_elapsed = dur(0) - 1;
          else begin
            m_phase   = (m_phase + 1) % 6;
            m_elapsed = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic h, input logic s);
    controller_reset = r;
    Hz1_enable       = h;
    side_sensor      = s;
    @(posedge clk);
    model_edge(r, h, s);
    #1;
    chk("sec_tick", sec_tick, m_tick);
    chk("phase", phase, m_phase);
    chk("time_left", time_left, dur(m_phase) - m_elapsed);
    chk("main_lights", main_lights, main_exp(m_phase));
    chk("side_lights", side_lights, side_exp(m_phase));
    chk("main_onehot", $countones(main_lights), 1);
    chk("side_onehot", $countones(side_lights), 1);
    chk("safety", (main_lights != 3'b100) && (side_lights != 3'b100), 0);
    if (sec_tick === 1'b1) ticks++;
  endtask

  // Periodic reference: 4 clocks high, 4 clocks low.
  task automatic tstep(input logic r, input logic s);
    step(r, ~hc[2], s);
    hc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tstep(1'b1, 1'b1);
    ticks = 0;
  endtask

  task automatic run_to_tick(input int n, input logic s);
    for (int i = 0; i < 400 && ticks < n; i++) tstep(1'b0, s);
    chk("reach_tick", ticks, n);
    tstep(1'b0, s);
  endtask

  task automatic run_to_phase(input int p, input logic s);
    for (int i = 0; i < 400; i++) begin
      tstep(1'b0, s);
      if (phase == 3'(p)) break;
    end
    chk("reach_phase", phase, p);
  endtask

  int seq_exp[15] = '{5, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};

  initial begin
    logic r, h, s;

    // Reset held 3 clocks with the reference high.
    hc = 0;
    do_reset();
    chk("rst_phase", phase, 5);
    chk("rst_time_left", time_left, 1);
    chk("rst_main", main_lights, 3'b100);
    chk("rst_side", side_lights, 3'b100);
    chk("rst_no_tick", sec_tick, 0);

    // Side vehicle always waiting: phase seen at each tick follows the full cycle.
    for (int i = 0; i < 400 && ticks < 15; i++) begin
      tstep(1'b0, 1'b1);
      if (sec_tick === 1'b1) chk("seq_phase", phase, seq_exp[ticks-1]);
    end
    chk("seq_ticks", ticks, 15);

    // No side vehicle: main green parks at time_left=1 until the sensor rises.
    do_reset();
    run_to_tick(7, 1'b0);
    chk("hold_phase", phase, 0);
    chk("hold_time_left", time_left, 1);
    run_to_tick(8, 1'b1);
    chk("release_phase", phase, 1);

    // One-clock reset in side green, then the cycle resumes.
    run_to_phase(3, 1'b1);
    tstep(1'b1, 1'b1);
    chk("midrst_phase", phase, 5);
    chk("midrst_main", main_lights, 3'b100);
    chk("midrst_side", side_lights, 3'b100);
    chk("midrst_time_left", time_left, 1);
    run_to_phase(0, 1'b1);

    // Reference stuck low for 100 clocks in main yellow freezes the controller.
    run_to_phase(1, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
    chk("stuck_phase", phase, 1);
    chk("stuck_time_left", time_left, 2);

    // Random sensor, occasional resets and irregular reference edges.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      h = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : ~hc[2];
      s = ($urandom_range(0, 2) != 0);
      step(r, h, s);
      hc++;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
